// File: rtl/iter_div.sv
// Iterative restoring divider: {remainder, quotient} after WIDTH+1 cycles (2 for a zero divisor).
// No input backpressure: start_i is only honoured in IDLE; with RESULT_HOLD the result waits for ack_i.
module iter_div #(
    parameter int WIDTH       = 32,
    parameter bit RESULT_HOLD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic                 annul_i,
    input  logic                 ack_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic                 div0_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DIVZERO, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH:0]     dvs_q, dvs_d;
    logic               negq_q, negq_d, negr_q, negr_d;
    logic               busy_q, busy_d, ready_q, ready_d, div0_q, div0_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic               a_neg, b_neg, ge;
    logic [WIDTH-1:0]   a_mag, diff_w, rem_step, quo_step, q_fin, r_fin;
    logic [WIDTH:0]     b_ext, b_mag, trial;

    // Magnitudes of the incoming operands; the divisor keeps an extra bit so
    // the most-negative value stays exact.
    assign a_neg = signed_i & opa_i[WIDTH-1];
    assign b_neg = signed_i & opb_i[WIDTH-1];
    assign a_mag = a_neg ? (~opa_i + WIDTH'(1)) : opa_i;
    assign b_ext = {b_neg, opb_i};
    assign b_mag = b_neg ? (~b_ext + (WIDTH+1)'(1)) : b_ext;

    // One restoring step: the dividend shifts out of quo_q into the partial remainder.
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign ge       = (trial >= dvs_q);
    assign diff_w   = trial[WIDTH-1:0] - dvs_q[WIDTH-1:0];
    assign rem_step = ge ? diff_w : trial[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], ge};
    assign q_fin    = negq_q ? (~quo_step + WIDTH'(1)) : quo_step;
    assign r_fin    = negr_q ? (~rem_step + WIDTH'(1)) : rem_step;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        div0_d  = div0_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    dvs_d  = b_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    // A zero divisor parks the raw dividend in quo_q for the remainder field.
                    if (opb_i == '0) begin
                        state_d = DIVZERO;
                        quo_d   = opa_i;
                    end else begin
                        state_d = RUN;
                        quo_d   = a_mag;
                    end
                end
            end
            RUN: begin
                if (annul_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        div0_d  = 1'b0;
                        res_d   = {r_fin, q_fin};
                    end
                end
            end
            DIVZERO: begin
                busy_d = 1'b0;
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    div0_d  = 1'b1;
                    res_d   = {quo_q, {WIDTH{1'b1}}};
                end
            end
            DONE: begin
                if (ack_i || (RESULT_HOLD == 1'b0)) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            div0_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            div0_q  <= div0_d;
            res_q   <= res_d;
        end
    end

    assign busy_o   = busy_q;
    assign ready_o  = ready_q;
    assign div0_o   = div0_q;
    assign result_o = res_q;

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 8..64).
REQ-002 SHALL have parameter RESULT_HOLD, default 1; 1 holds the result until acknowledged, 0 auto-returns to idle after one ready cycle.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  request a division; sampled only in IDLE.
REQ-006 SHALL have port signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-007 SHALL have port annul_i  input  1  abort the operation in flight.
REQ-008 SHALL have port ack_i  input  1  consumer has taken result_o (RESULT_HOLD=1 only).
REQ-009 SHALL have port opa_i  input  WIDTH  dividend.
REQ-010 SHALL have port opb_i  input  WIDTH  divisor.
REQ-011 SHALL have port busy_o  output  1  operation accepted and not yet complete.
REQ-012 SHALL have port ready_o  output  1  result_o valid.
REQ-013 SHALL have port div0_o  output  1  completed operation had divisor zero; valid with ready_o.
REQ-014 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}, remainder in upper half (hi/lo order).

Function
REQ-015 SHALL implement states IDLE, RUN, DIVZERO, DONE.
REQ-016 IDLE: start_i=1 and annul_i=0 at edge T SHALL capture operands and sign mode, and go to DIVZERO if opb_i=0, else RUN.
REQ-017 RUN SHALL perform one restoring shift-subtract step per cycle on magnitudes, with an iteration counter from 0 to WIDTH-1; after exactly WIDTH RUN cycles it SHALL go to DONE.
REQ-018 ready_o SHALL rise at T+WIDTH+1 for a nonzero divisor and at T+2 for a zero divisor.
REQ-019 DIVZERO SHALL last one cycle, then DONE with quotient all ones, remainder = original dividend, and div0_o=1.
REQ-020 Signed mode SHALL divide absolute values, negate the quotient when operand signs differ, and give the remainder the sign of the dividend (truncating division).
REQ-021 Signed most-negative / -1 SHALL yield quotient = most-negative value and remainder 0, with no error flag.
REQ-022 The magnitude datapath SHALL be WIDTH+1 bits wide so that |most-negative| is represented exactly.
REQ-023 busy_o SHALL be 1 in RUN and DIVZERO only; ready_o SHALL be 1 in DONE only.
REQ-024 result_o and div0_o SHALL update only on entry to DONE and hold their value otherwise, including through IDLE.
REQ-025 DONE with RESULT_HOLD=1 SHALL remain until ack_i=1, then go to IDLE; with RESULT_HOLD=0 it SHALL go to IDLE after one cycle regardless of ack_i.
REQ-026 start_i SHALL be ignored in RUN, DIVZERO and DONE; if start_i and ack_i are both 1 in DONE, the block SHALL go to IDLE and not accept the start.
REQ-027 annul_i=1 in RUN or DIVZERO SHALL return the block to IDLE next cycle, with no ready_o pulse and result_o unchanged.
REQ-028 annul_i=1 in DONE or IDLE SHALL have no effect; annul_i with start_i in IDLE SHALL block acceptance.
REQ-029 Operands SHALL be captured internally, so later changes to opa_i, opb_i or signed_i have no effect on the operation in flight.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, counter 0, busy_o=0, ready_o=0, div0_o=0 and result_o=0, including mid-operation.
REQ-031 After rst deasserts, the first accepted start SHALL behave per REQ-016 to REQ-018 with no residual state.

Verification (WIDTH=32 unless stated)
REQ-032 Unsigned 100/7 started at T SHALL give busy_o from T+1 to T+32, ready_o at T+33, and result_o=0x00000002_0000000E.
REQ-033 Signed -7/2 (0xFFFFFFF9 / 0x00000002) SHALL give result_o=0xFFFFFFFF_FFFFFFFD; signed 0x80000000/0xFFFFFFFF SHALL give 0x00000000_80000000.
REQ-034 Divide-by-zero 5/0 SHALL give ready_o at T+2, div0_o=1, and result_o=0x00000005_FFFFFFFF.
REQ-035 annul_i at T+10 SHALL make busy_o=0 at T+11 with no ready_o; a following 9/3 SHALL give 0x00000000_00000003.
REQ-036 RESULT_HOLD=1 with ack_i held low for 20 cycles SHALL keep ready_o and result_o stable, and a start_i pulse during that time SHALL be ignored; rst=0 at T+5 SHALL clear all outputs that cycle.
REQ-037 A WIDTH=8 instance computing unsigned 200/3 SHALL give ready_o at T+9 and result_o=0x02_42.
